// File: rtl/modulation_segment_serializer_if.sv
// Bus bundle for modulation_segment_serializer: start request, frame words in, modulated stream out.
interface modulation_segment_serializer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] segment_0;
    logic [WIDTH-1:0] segment_1;
    logic [WIDTH-1:0] segment_2;
    logic [WIDTH-1:0] segment_3;
    logic [WIDTH-1:0] segment_4;
    logic [WIDTH-1:0] segment_5;
    logic [WIDTH-1:0] segment_6;
    logic [WIDTH-1:0] segment_7;
    logic [WIDTH-1:0] segment_8;
    logic [WIDTH-1:0] segment_9;
    logic [WIDTH-1:0] output_bit;
    logic             out_valid;
    logic             out_last;
    logic [3:0]       segment_index;
    logic             busy;
    logic             done;

    modport master (
        output start, segment_0, segment_1, segment_2, segment_3, segment_4,
               segment_5, segment_6, segment_7, segment_8, segment_9,
        input  output_bit, out_valid, out_last, segment_index, busy, done
    );

    modport slave (
        input  start, segment_0, segment_1, segment_2, segment_3, segment_4,
               segment_5, segment_6, segment_7, segment_8, segment_9,
        output output_bit, out_valid, out_last, segment_index, busy, done
    );
endinterface

// File: rtl/modulation_segment_serializer.sv
// Snapshots a frame of segments on a start level, warms up, then emits one word per cycle.
// Optional MOD_SCRAMBLE_EN: XOR each emitted word with a 32-bit LFSR seeded at snapshot.
module modulation_segment_serializer #(
    parameter int WIDTH   = 32,
    parameter int NUM_SEG = 10,
    parameter int WARMUP  = 3
) (
    input logic clk,
    input logic reset,
    modulation_segment_serializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WARM, SEND, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       warm_cnt, warm_cnt_nxt;
    logic [3:0]       idx, idx_nxt;
    logic             armed;
    logic             snapshot;
    logic [WIDTH-1:0] seg_in [0:9];
    logic [WIDTH-1:0] bank   [0:9];
    logic [WIDTH-1:0] word_nxt;

`ifdef MOD_SCRAMBLE_EN
    localparam logic [31:0] LFSR_SEED = 32'hACE10001;
    logic [31:0] lfsr;
`endif

    always_comb begin
        seg_in[0] = bus.segment_0;
        seg_in[1] = bus.segment_1;
        seg_in[2] = bus.segment_2;
        seg_in[3] = bus.segment_3;
        seg_in[4] = bus.segment_4;
        seg_in[5] = bus.segment_5;
        seg_in[6] = bus.segment_6;
        seg_in[7] = bus.segment_7;
        seg_in[8] = bus.segment_8;
        seg_in[9] = bus.segment_9;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A dropped start in WARM or SEND abandons the frame without a done pulse.
    always_comb begin
        state_nxt    = state;
        warm_cnt_nxt = warm_cnt;
        idx_nxt      = idx;
        snapshot     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && armed) begin
                    state_nxt    = WARM;
                    warm_cnt_nxt = 4'(WARMUP - 1);
                    snapshot     = 1'b1;
                end
            end
            WARM: begin
                if (!bus.start) begin
                    state_nxt = IDLE;
                end else if (warm_cnt == '0) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end else begin
                    warm_cnt_nxt = warm_cnt - 4'd1;
                end
            end
            SEND: begin
                if (!bus.start)                       state_nxt = IDLE;
                else if (idx == 4'(NUM_SEG - 1))      state_nxt = DONE;
                else                                  idx_nxt   = idx + 4'd1;
            end
            DONE: begin
                if (!bus.start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word_nxt = '0;
        if (idx_nxt < 4'd10) word_nxt = bank[idx_nxt];
`ifdef MOD_SCRAMBLE_EN
        word_nxt = word_nxt ^ WIDTH'(lfsr);
`endif
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt          <= '0;
            idx               <= '0;
            armed             <= 1'b0;
            bus.output_bit    <= '0;
            bus.segment_index <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_last      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            for (int unsigned i = 0; i < 10; i++) bank[i] <= '0;
        end else begin
            warm_cnt <= warm_cnt_nxt;
            idx      <= idx_nxt;
            if (snapshot)                       armed <= 1'b0;
            else if (state == IDLE && !bus.start) armed <= 1'b1;
            if (snapshot) begin
                for (int unsigned i = 0; i < 10; i++) bank[i] <= seg_in[i];
            end
            bus.out_valid     <= (state_nxt == SEND);
            bus.output_bit    <= (state_nxt == SEND) ? word_nxt : '0;
            bus.segment_index <= (state_nxt == SEND) ? idx_nxt : '0;
            bus.out_last      <= (state_nxt == SEND) && (idx_nxt == 4'(NUM_SEG - 1));
            bus.busy          <= (state_nxt == WARM) || (state_nxt == SEND);
            bus.done          <= (state == SEND) && (state_nxt == DONE);
        end
    end

`ifdef MOD_SCRAMBLE_EN
    always_ff @(posedge clk) begin
        if (reset || snapshot)     lfsr <= LFSR_SEED;
        else if (state_nxt == SEND) lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end
`endif
endmodule

// File: tb/tb_modulation_segment_serializer.sv
// Randomized bench for modulation_segment_serializer against a frame-level reference model.
module tb_modulation_segment_serializer;
    localparam int L = 1200;
    localparam int W = 3;
    localparam int S = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    modulation_segment_serializer_if #(.WIDTH(32)) bus ();

    modulation_segment_serializer #(.WIDTH(32), .NUM_SEG(S), .WARMUP(W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic        st [0:L-1];
    logic        rs [0:L-1];
    logic [31:0] sg [0:L-1][0:9];
    logic [31:0] e_ob [0:L-1];
    logic [31:0] e_ix [0:L-1];
    logic        e_v [0:L-1];
    logic        e_l [0:L-1];
    logic        e_b [0:L-1];
    logic        e_d [0:L-1];

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_nth(int unsigned n);
        logic [31:0] r;
        r = 32'hACE10001;
        for (int unsigned i = 0; i < n; i++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
        return r;
    endfunction

    initial begin
        logic        lvl;
        int          fs;
        int          p;
        int          k;
        bit          in_done;
        bit          armed;
        logic [31:0] held [0:9];
        logic [31:0] base;

        // Directed prologue: basic frame, snapshot, held start, abort/restart, reset mid-SEND.
`ifdef MOD_SCRAMBLE_EN
        base = 32'h0;
`else
        base = 32'h1000_0000;
`endif
        for (int c = 0; c < L; c++) begin
            rs[c] = 1'b0;
            st[c] = 1'b0;
            for (int j = 0; j < 10; j++) sg[c][j] = (c < 5) ? base + 32'(j) : 32'hFFFF_FFFF;
        end
        rs[0] = 1'b1; rs[1] = 1'b1;
        for (int c = 3;  c <= 33;  c++) st[c] = 1'b1;
        for (int c = 36; c <= 42;  c++) st[c] = 1'b1;
        for (int c = 46; c <= 61;  c++) st[c] = 1'b1;
        for (int c = 64; c <= 80;  c++) st[c] = 1'b1;
        for (int c = 82; c <= 100; c++) st[c] = 1'b1;
        rs[73] = 1'b1;
        lvl = 1'b1;
        for (int c = 101; c < L; c++) begin
            if ($urandom_range(19) == 0) lvl = ~lvl;
            st[c] = lvl;
            rs[c] = ($urandom_range(149) == 0);
            for (int j = 0; j < 10; j++) sg[c][j] = $urandom;
        end

        // Reference model: frame started at cycle fs; cycle fs+p is warmup for p<=W,
        // word p-W-1 for p<=W+S, then the completion cycle.
        for (int c = 0; c < L; c++) begin
            e_ob[c] = '0; e_ix[c] = '0; e_v[c] = 1'b0; e_l[c] = 1'b0; e_b[c] = 1'b0; e_d[c] = 1'b0;
        end
        fs = -1; in_done = 1'b0; armed = 1'b0;
        for (int j = 0; j < 10; j++) held[j] = '0;
        for (int c = 0; c < L - 1; c++) begin
            if (rs[c]) begin
                fs = -1; in_done = 1'b0; armed = 1'b0;
            end else if (fs >= 0) begin
                if (!st[c]) begin
                    fs = -1;
                end else begin
                    p = c + 1 - fs;
                    if (p <= W) begin
                        e_b[c+1] = 1'b1;
                    end else if (p <= W + S) begin
                        k = p - W - 1;
                        e_b[c+1]  = 1'b1;
                        e_v[c+1]  = 1'b1;
                        e_ix[c+1] = 32'(k);
                        e_l[c+1]  = (k == S - 1);
`ifdef MOD_SCRAMBLE_EN
                        e_ob[c+1] = held[k] ^ lfsr_nth(k);
`else
                        e_ob[c+1] = held[k];
`endif
                    end else begin
                        e_d[c+1] = 1'b1;
                        fs = -1;
                        in_done = 1'b1;
                    end
                end
            end else if (in_done) begin
                if (!st[c]) in_done = 1'b0;
            end else if (st[c] && armed) begin
                fs = c;
                armed = 1'b0;
                for (int j = 0; j < 10; j++) held[j] = sg[c][j];
                e_b[c+1] = 1'b1;
            end else if (!st[c]) begin
                armed = 1'b1;
            end
        end

        reset = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        for (int c = 0; c < L; c++) begin
            #1;
            reset         = rs[c];
            bus.start     = st[c];
            bus.segment_0 = sg[c][0];
            bus.segment_1 = sg[c][1];
            bus.segment_2 = sg[c][2];
            bus.segment_3 = sg[c][3];
            bus.segment_4 = sg[c][4];
            bus.segment_5 = sg[c][5];
            bus.segment_6 = sg[c][6];
            bus.segment_7 = sg[c][7];
            bus.segment_8 = sg[c][8];
            bus.segment_9 = sg[c][9];
            @(negedge clk);
            if (c >= 1) begin
                check_eq("output_bit",    bus.output_bit,           e_ob[c]);
                check_eq("segment_index", {28'd0, bus.segment_index}, e_ix[c]);
                check_eq("out_valid",     {31'd0, bus.out_valid},   {31'd0, e_v[c]});
                check_eq("out_last",      {31'd0, bus.out_last},    {31'd0, e_l[c]});
                check_eq("busy",          {31'd0, bus.busy},        {31'd0, e_b[c]});
                check_eq("done",          {31'd0, bus.done},        {31'd0, e_d[c]});
            end
            case (c)
                1:  check_eq("reset_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef MOD_SCRAMBLE_EN
                7:  check_eq("scr_word0", bus.output_bit, 32'hACE10001);
                8:  check_eq("scr_word1", bus.output_bit, 32'h59C20003);
`else
                7:  check_eq("first_word", bus.output_bit, 32'h1000_0000);
                16: check_eq("last_word",  bus.output_bit, 32'h1000_0009);
`endif
                6:  check_eq("warm_no_valid", {31'd0, bus.out_valid}, 32'd0);
                16: check_eq("last_flag",  {31'd0, bus.out_last}, 32'd1);
                17: check_eq("done_pulse", {31'd0, bus.done}, 32'd1);
                18: check_eq("done_once",  {31'd0, bus.done}, 32'd0);
                30: check_eq("held_no_retrig", {31'd0, bus.busy}, 32'd0);
                44: check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
                50: check_eq("restart_idx0", {31'd0, bus.out_valid}, 32'd1);
                74: check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
                78: check_eq("no_rearm", {31'd0, bus.out_valid}, 32'd0);
                96: check_eq("rearm_done", {31'd0, bus.done}, 32'd1);
                default: ;
            endcase
            @(posedge clk);
        end
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/modulation_segment_serializer.md
MODULATION_SEGMENT_SERIALIZER -- requirements
Module: modulation_segment_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the bit width of each segment and of output_bit.
REQ-002 The block SHALL have parameter NUM_SEG, default 10, the number of segments per frame, legal range 2..15.
REQ-003 The block SHALL have parameter WARMUP, default 3, the number of fill cycles before the first word is emitted, legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, level request; it SHALL be held high for the whole frame.
REQ-007 The block SHALL have ports segment_0 .. segment_9, input, WIDTH bits each, frame words in emission order.
REQ-008 The block SHALL have port output_bit, output, WIDTH bits, modulated word stream.
REQ-009 The block SHALL have port out_valid, output, 1 bit, output_bit carries a frame word this cycle.
REQ-010 The block SHALL have port out_last, output, 1 bit, high with the word from segment NUM_SEG-1.
REQ-011 The block SHALL have port segment_index, output, 4 bits, index of the word on output_bit.
REQ-012 The block SHALL have port busy, output, 1 bit, high in WARM and SEND.
REQ-013 The block SHALL have port done, output, 1 bit, one-cycle pulse on frame completion.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WARM, SEND and DONE; all outputs SHALL be registered.
REQ-015 Cycle N is the cycle in which start is high in IDLE; at the end of N the FSM SHALL snapshot all segments into a holding bank and enter WARM.
REQ-016 After the snapshot, segment input changes SHALL NOT affect the frame in flight.
REQ-017 WARM SHALL last exactly WARMUP cycles (N+1..N+3 by default), with a down-counter reloaded on entry.
REQ-018 SEND SHALL last exactly NUM_SEG cycles (N+4..N+13 by default); in cycle N+4+k: out_valid=1, segment_index=k, output_bit=held segment_k (after REQ-029 if enabled).
REQ-019 out_last SHALL be high only when segment_index=NUM_SEG-1 and out_valid=1.
REQ-020 The index counter SHALL reach NUM_SEG-1 and transition to DONE without wrapping to 0 within a frame.
REQ-021 In DONE (first cycle N+14), done SHALL be 1 for exactly one cycle; busy=0, out_valid=0, and output_bit SHALL hold 0.
REQ-022 The FSM SHALL stay in DONE while start=1 (no retrigger on a held level) and SHALL return to IDLE in the cycle after start is sampled 0.
REQ-023 If start is sampled 0 in WARM or SEND, the frame SHALL abort: next cycle the FSM is in IDLE, with out_valid, out_last, busy and done at 0, no done pulse, and the rest of the frame discarded.
REQ-024 A new frame SHALL require start to be low for at least one cycle in IDLE before the rising level is accepted.
REQ-025 Whenever out_valid=0, output_bit and segment_index SHALL be driven to 0.

Reset
REQ-026 When reset=1 at a rising edge, the FSM SHALL go to IDLE and output_bit, segment_index, out_valid, out_last, busy and done SHALL all be 0 on the next cycle.
REQ-027 Reset SHALL take priority over start and SHALL abort any frame in progress with no done pulse.
REQ-028 The holding bank SHALL be cleared to 0 on reset.

Configuration
REQ-029 With macro MOD_SCRAMBLE_EN defined, output_bit SHALL equal the held segment XOR a 32-bit LFSR (shift left, bit0 = b31^b21^b1^b0), seeded with 32'hACE10001 at snapshot and advanced once per emitted word.
REQ-030 With MOD_SCRAMBLE_EN undefined, output_bit SHALL equal the held segment unmodified, and no LFSR logic SHALL be present.

Verification
REQ-031 Basic frame: segment_k=32'h1000_0000+k, start held high from cycle 0 -> out_valid in cycles 4..13 with output_bit 32'h10000000..32'h10000009, out_last in cycle 13, done in cycle 14.
REQ-032 Snapshot: change all segments to 32'hFFFFFFFF in cycle 2 -> the emitted words still equal the cycle-0 values.
REQ-033 Abort: drop start in cycle 7 -> out_valid=0 and busy=0 from cycle 8, no done pulse; restarting in cycle 10 gives a first word in cycle 14.
REQ-034 Held start: keep start high to cycle 30 -> a single frame, done pulses once, no second out_valid.
REQ-035 Reset mid-SEND: reset in cycle 9 -> all outputs 0 in cycle 10 and the FSM is in IDLE; a frame completes normally only after start is low for a cycle and then high again.
REQ-036 With MOD_SCRAMBLE_EN and all segments 0 -> the first word is 32'hACE10001 and the second word is 32'h59C20003.
